// File: rtl/key_mode_ctrl.sv
// Front-panel key controller: qualifies scanner key presses and maps them onto
// measurement mode, gate-length stepping (with auto-repeat) and a renew pulse.
module key_mode_ctrl #(
    parameter int NUM_MODES  = 3,
    parameter int GATE_STEPS = 10,
    parameter int STEP_CYC   = 50_000_000,
    parameter int MARGIN_CYC = 10_000_000,
    parameter int CW         = 30,
    parameter int STABLE_CYC = 4,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 10_000_000
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [3:0]    key_value,
    output logic [CW-1:0] gate_time,
    output logic [CW-1:0] time_max,
    output logic [3:0]    mode,
    output logic [3:0]    gate_idx,
    output logic [3:0]    disp_digit,
    output logic          renew,
    output logic          cfg_changed
);

    localparam int CNT_MAX0 = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_MAX  = (CNT_MAX0 > STABLE_CYC) ? CNT_MAX0 : STABLE_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] QUAL_END = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_END  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_END  = CNT_W'(REPEAT_PER - 1);

    localparam logic [CW-1:0] STEP_V   = CW'(STEP_CYC);
    localparam logic [CW-1:0] TMAX_RST = CW'(STEP_CYC + MARGIN_CYC);
    localparam logic [CW-1:0] GATE_TOP = CW'(GATE_STEPS * STEP_CYC);
    localparam logic [CW-1:0] TMAX_TOP = CW'(GATE_STEPS * STEP_CYC + MARGIN_CYC);

    localparam logic [3:0] NM     = 4'(NUM_MODES);
    localparam logic [3:0] GS     = 4'(GATE_STEPS);
    localparam logic [3:0] KEY_UP = 4'd10;
    localparam logic [3:0] KEY_DN = 4'd11;

    typedef enum logic [1:0] {IDLE, QUAL, HELD, RPT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       key_r;
    logic             armed;
    logic             fire;
    logic             is_rpt;
    logic [3:0]       mode_r, prev_mode;
    logic             adjusting;

    assign is_rpt = (key_r == KEY_UP) || (key_r == KEY_DN);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            key_r <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && state_nxt == QUAL)
                key_r <= key_value;
            // A key still held across reset must be released before it counts.
            if (!key_valid)
                armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (key_valid && armed)
                    state_nxt = QUAL;
            end
            QUAL: begin
                if (!key_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == QUAL_END) begin
                    fire      = 1'b1;
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end
            end
            HELD: begin
                if (!key_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!is_rpt) begin
                    cnt_nxt = cnt;
                end else if (cnt == DLY_END) begin
                    fire      = 1'b1;
                    state_nxt = RPT;
                    cnt_nxt   = '0;
                end
            end
            RPT: begin
                if (!key_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == PER_END) begin
                    fire    = 1'b1;
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Gate length moves by one step per action so no multiplier is needed.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            gate_idx    <= 4'd1;
            gate_time   <= STEP_V;
            time_max    <= TMAX_RST;
            mode_r      <= 4'd1;
            prev_mode   <= 4'd1;
            adjusting   <= 1'b0;
            renew       <= 1'b0;
            cfg_changed <= 1'b0;
        end else begin
            renew       <= 1'b0;
            cfg_changed <= 1'b0;
            if (fire) begin
                if (key_r == 4'd0) begin
                    mode_r    <= prev_mode;
                    adjusting <= 1'b0;
                    prev_mode <= 4'd1;
                    renew     <= 1'b1;
                end else if (key_r <= NM) begin
                    if (!adjusting)
                        prev_mode <= mode_r;
                    mode_r      <= key_r;
                    adjusting   <= 1'b0;
                    cfg_changed <= 1'b1;
                end else if (key_r == KEY_UP) begin
                    if (!adjusting)
                        prev_mode <= mode_r;
                    adjusting   <= 1'b1;
                    cfg_changed <= 1'b1;
                    if (gate_idx < GS) begin
                        gate_idx  <= gate_idx + 4'd1;
                        gate_time <= gate_time + STEP_V;
                        time_max  <= time_max + STEP_V;
                    end else begin
                        gate_idx  <= 4'd1;
                        gate_time <= STEP_V;
                        time_max  <= TMAX_RST;
                    end
                end else if (key_r == KEY_DN) begin
                    if (!adjusting)
                        prev_mode <= mode_r;
                    adjusting   <= 1'b1;
                    cfg_changed <= 1'b1;
                    if (gate_idx > 4'd1) begin
                        gate_idx  <= gate_idx - 4'd1;
                        gate_time <= gate_time - STEP_V;
                        time_max  <= time_max - STEP_V;
                    end else begin
                        gate_idx  <= GS;
                        gate_time <= GATE_TOP;
                        time_max  <= TMAX_TOP;
                    end
                end
            end
        end
    end

    assign mode       = adjusting ? 4'd0 : mode_r;
    assign disp_digit = adjusting ? gate_idx : mode_r;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Bench for key_mode_ctrl: directed press table, hand-written timing/reset
// sequences, then random presses checked against a press-level reference model.
module tb_key_mode_ctrl;

    localparam int NM = 3, GS = 10, STEP = 100, MARG = 20, CW = 30;
    localparam int STAB = 4, RDLY = 50, RPER = 10;
    localparam int FIRST = STAB + 1;         // hold count of the first action
    localparam int RPT0  = STAB + 1 + RDLY;  // hold count of the first repeat

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          key_valid = 1'b0;
    logic [3:0]    key_value = 4'd0;
    logic [CW-1:0] gate_time, time_max;
    logic [3:0]    mode, gate_idx, disp_digit;
    logic          renew, cfg_changed;

    key_mode_ctrl #(
        .NUM_MODES(NM), .GATE_STEPS(GS), .STEP_CYC(STEP), .MARGIN_CYC(MARG), .CW(CW),
        .STABLE_CYC(STAB), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .key_valid(key_valid), .key_value(key_value),
        .gate_time(gate_time), .time_max(time_max), .mode(mode), .gate_idx(gate_idx),
        .disp_digit(disp_digit), .renew(renew), .cfg_changed(cfg_changed)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0, bad = 0;

    // Reference model: press-level view (hold count -> action schedule).
    int m_mode, m_prev, m_idx, m_t, m_key;
    bit m_adj, m_need_rel, m_renew, m_cfg;
    int n_renew, n_cfg;

    typedef struct {
        int key; int hold; int gap;
        int e_mode; int e_idx; int e_disp; int e_gt; int e_rn; int e_cf;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 1; m_prev = 1; m_idx = 1; m_adj = 0; m_t = 0;
        m_need_rel = 1; m_renew = 0; m_cfg = 0;
    endfunction

    function automatic void model_apply(int k);
        if (k >= 1 && k <= NM) begin
            if (!m_adj) m_prev = m_mode;
            m_mode = k; m_adj = 0; m_cfg = 1;
        end else if (k == 10) begin
            if (!m_adj) m_prev = m_mode;
            m_adj = 1; m_cfg = 1;
            m_idx = (m_idx == GS) ? 1 : m_idx + 1;
        end else if (k == 11) begin
            if (!m_adj) m_prev = m_mode;
            m_adj = 1; m_cfg = 1;
            m_idx = (m_idx == 1) ? GS : m_idx - 1;
        end else if (k == 0) begin
            m_mode = m_prev; m_adj = 0; m_prev = 1; m_renew = 1;
        end
    endfunction

    function automatic void model_edge(bit v, int k);
        bit fire = 0;
        m_renew = 0; m_cfg = 0;
        if (v) begin
            if (m_t == 0) begin
                if (!m_need_rel) begin m_t = 1; m_key = k; end
            end else m_t++;
            if (m_t == FIRST) fire = 1;
            else if ((m_key == 10 || m_key == 11) && m_t >= RPT0 && (m_t - RPT0) % RPER == 0)
                fire = 1;
        end else begin
            m_t = 0; m_need_rel = 0;
        end
        if (fire) model_apply(m_key);
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, " mode"},  32'(mode),        32'(m_adj ? 0 : m_mode));
        chk({tag, " idx"},   32'(gate_idx),    32'(m_idx));
        chk({tag, " gate"},  32'(gate_time),   32'(m_idx * STEP));
        chk({tag, " tmax"},  32'(time_max),    32'(m_idx * STEP + MARG));
        chk({tag, " disp"},  32'(disp_digit),  32'(m_adj ? m_idx : m_mode));
        chk({tag, " renew"}, 32'(renew),       32'(m_renew));
        chk({tag, " cfg"},   32'(cfg_changed), 32'(m_cfg));
    endtask

    // Called at a negedge: drive, clock, update model, check at next negedge.
    task automatic cyc(input bit v, input int k);
        key_valid = v;
        key_value = 4'(k);
        @(posedge sys_clk);
        model_edge(v, k);
        @(negedge sys_clk);
        check_outs("cyc");
        n_renew += int'(renew);
        n_cfg   += int'(cfg_changed);
    endtask

    task automatic press(input int k, input int hold, input int gap);
        repeat (hold) cyc(1'b1, k);
        repeat (gap) cyc(1'b0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{10,   6, 3, 0,  2,  2,  200, 0,  1};
        tbl[1]  = '{10,   6, 3, 0,  3,  3,  300, 0,  1};
        tbl[2]  = '{10,   6, 3, 0,  4,  4,  400, 0,  1};
        tbl[3]  = '{ 0,   6, 3, 2,  4,  2,  400, 1,  0};
        tbl[4]  = '{ 7,   6, 3, 2,  4,  2,  400, 0,  0};
        tbl[5]  = '{13,   6, 3, 2,  4,  2,  400, 0,  0};
        tbl[6]  = '{11,   6, 3, 0,  3,  3,  300, 0,  1};
        tbl[7]  = '{11,   6, 3, 0,  2,  2,  200, 0,  1};
        tbl[8]  = '{11,   6, 3, 0,  1,  1,  100, 0,  1};
        tbl[9]  = '{10, 140, 3, 0,  1,  1,  100, 0, 10};
        tbl[10] = '{11,   6, 3, 0, 10, 10, 1000, 0,  1};
        tbl[11] = '{ 1,   6, 3, 1, 10,  1, 1000, 0,  1};

        model_reset();
        n_renew = 0; n_cfg = 0;
        repeat (2) @(negedge sys_clk);
        chk("rst gate", 32'(gate_time), 32'd100);
        chk("rst tmax", 32'(time_max), 32'd120);
        chk("rst mode", 32'(mode), 32'd1);
        chk("rst disp", 32'(disp_digit), 32'd1);
        chk("rst renew", 32'(renew), 32'd0);
        reset = 1'b0;
        repeat (2) cyc(1'b0, 0);

        // Short glitch on key 2: no action.
        n_cfg = 0;
        press(2, 3, 3);
        chk("glitch cfg", 32'(n_cfg), 32'd0);
        chk("glitch mode", 32'(mode), 32'd1);

        // Key 2 held: mode changes exactly STABLE_CYC+1 cycles after rise.
        n_cfg = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 2);
            chk("t mode", 32'(mode), (i >= FIRST) ? 32'd2 : 32'd1);
            chk("t cfg", 32'(cfg_changed), 32'(i == FIRST));
        end
        repeat (3) cyc(1'b0, 0);
        chk("t cfg count", 32'(n_cfg), 32'd1);

        for (int r = 0; r < 12; r++) begin
            n_renew = 0; n_cfg = 0;
            press(tbl[r].key, tbl[r].hold, tbl[r].gap);
            chk($sformatf("tbl%0d mode", r), 32'(mode), 32'(tbl[r].e_mode));
            chk($sformatf("tbl%0d idx", r), 32'(gate_idx), 32'(tbl[r].e_idx));
            chk($sformatf("tbl%0d disp", r), 32'(disp_digit), 32'(tbl[r].e_disp));
            chk($sformatf("tbl%0d gate", r), 32'(gate_time), 32'(tbl[r].e_gt));
            chk($sformatf("tbl%0d tmax", r), 32'(time_max), 32'(tbl[r].e_gt + MARG));
            chk($sformatf("tbl%0d renews", r), 32'(n_renew), 32'(tbl[r].e_rn));
            chk($sformatf("tbl%0d cfgs", r), 32'(n_cfg), 32'(tbl[r].e_cf));
        end

        // Reset in the middle of auto-repeat, key kept held afterwards.
        repeat (70) cyc(1'b1, 11);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rpt-rst idx", 32'(gate_idx), 32'd1);
        chk("rpt-rst gate", 32'(gate_time), 32'd100);
        chk("rpt-rst tmax", 32'(time_max), 32'd120);
        chk("rpt-rst mode", 32'(mode), 32'd1);
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        n_renew = 0; n_cfg = 0;
        repeat (80) cyc(1'b1, 11);
        chk("held idx", 32'(gate_idx), 32'd1);
        chk("held mode", 32'(mode), 32'd1);
        chk("held pulses", 32'(n_cfg + n_renew), 32'd0);
        repeat (2) cyc(1'b0, 0);
        press(3, 8, 2);
        chk("repress mode", 32'(mode), 32'd3);

        // Random presses, including key changes while held.
        for (int p = 0; p < 250; p++) begin
            int keys[11] = '{0, 1, 2, 3, 5, 7, 9, 10, 11, 12, 15};
            int k, hold;
            k = keys[$urandom_range(0, 10)];
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(50, 120))
                                               : int'($urandom_range(1, 12));
            for (int i = 0; i < hold; i++)
                cyc(1'b1, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : k);
            repeat ($urandom_range(1, 4)) cyc(1'b0, int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
